// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: decodes funct3 size/sign, issues one lane-aligned
// memory request with a byte mask and returns extended load data or an error code.
module ysyx_24100005_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 2);
  localparam bit IS64   = (DATA_W == 64);
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic              write_q, write_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_write_q, mem_req_write_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [DATA_W-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [STRB_W-1:0] mem_req_wmask_q, mem_req_wmask_d;

  // Request classification and lane encoding, straight from the request inputs.
  logic              req_illegal;
  logic              req_misal;
  logic [OFF_W-1:0]  off_in;
  logic [7:0]        mask_raw;
  logic [STRB_W-1:0] enc_wmask;
  logic [DATA_W-1:0] enc_wdata;
  logic [ADDR_W-1:0] enc_addr;

  always_comb begin
    off_in = req_addr[OFF_W-1:0];

    if (req_write) begin
      req_illegal = req_funct3[2] | (!IS64 && (req_funct3 == 3'b011));
    end else begin
      req_illegal = (req_funct3 == 3'b111) |
                    (!IS64 && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    end

    case (req_funct3[1:0])
      2'b00:   begin req_misal = 1'b0;            mask_raw = 8'h01; end
      2'b01:   begin req_misal = req_addr[0];     mask_raw = 8'h03; end
      2'b10:   begin req_misal = |req_addr[1:0];  mask_raw = 8'h0F; end
      default: begin req_misal = |req_addr[2:0];  mask_raw = 8'hFF; end
    endcase

    enc_wmask = STRB_W'(mask_raw) << off_in;
    enc_wdata = req_wdata << {off_in, 3'b000};
    enc_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Load result: shift the addressed lane down, then sign/zero-extend by size.
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;
  logic              sgn;
  int                nbits;

  always_comb begin
    shifted = mem_rsp_rdata >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   begin sgn = shifted[7];        nbits = 8;  end
      2'b01:   begin sgn = shifted[15];       nbits = 16; end
      2'b10:   begin sgn = shifted[31];       nbits = 32; end
      default: begin sgn = shifted[DATA_W-1]; nbits = DATA_W; end
    endcase
    sgn = sgn & ~f3_q[2];
    for (int i = 0; i < DATA_W; i++) begin
      load_data[i] = (i < nbits) ? shifted[i] : sgn;
    end
  end

  logic to_hit;
  assign to_hit = TO_EN && (cnt_q >= CNT_LIM);

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    f3_d            = f3_q;
    off_d           = off_q;
    cnt_d           = cnt_q;
    resp_rdata_d    = resp_rdata_q;
    resp_err_d      = resp_err_q;
    mem_req_write_d = mem_req_write_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wmask_d = mem_req_wmask_q;

    if ((state_q == S_MREQ || state_q == S_MWAIT) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          f3_d    = req_funct3;
          off_d   = off_in;
          if (req_illegal) begin
            state_d      = S_RESP;
            resp_err_d   = ERR_ILL;
            resp_rdata_d = '0;
          end else if (req_misal) begin
            state_d      = S_RESP;
            resp_err_d   = ERR_MIS;
            resp_rdata_d = '0;
          end else begin
            state_d         = S_MREQ;
            cnt_d           = '0;
            mem_req_write_d = req_write;
            mem_req_addr_d  = enc_addr;
            mem_req_wdata_d = req_write ? enc_wdata : '0;
            mem_req_wmask_d = req_write ? enc_wmask : '0;
          end
        end
      end
      S_MREQ: begin
        if (mem_req_ready) begin
          state_d = S_MWAIT;
        end else if (to_hit) begin
          state_d      = S_RESP;
          resp_err_d   = ERR_TO;
          resp_rdata_d = '0;
        end
      end
      S_MWAIT: begin
        if (mem_rsp_valid) begin
          state_d      = S_RESP;
          resp_err_d   = ERR_OK;
          resp_rdata_d = write_q ? '0 : load_data;
        end else if (to_hit) begin
          state_d      = S_RESP;
          resp_err_d   = ERR_TO;
          resp_rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake flags are registered copies of the next state.
    req_ready_d     = (state_d == S_IDLE);
    resp_valid_d    = (state_d == S_RESP);
    mem_req_valid_d = (state_d == S_MREQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      write_q         <= 1'b0;
      f3_q            <= '0;
      off_q           <= '0;
      cnt_q           <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wmask_q <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wmask_q <= mem_req_wmask_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wmask = mem_req_wmask_q;

endmodule
